// File: rtl/sample_mac_pipe.sv
// -----------------------------------------------------------------------------
// sample_mac_pipe
// Pipelined unsigned(A) x signed(B) multiply / multiply-accumulate unit.
// MODE 0 emits one truncated product per beat. MODE 1 sums products over a
// frame closed by in_last and emits only the frame total.
// Latency is NUM_STAGE+1 edges counting the accept edge. A global stall
// freezes every register whenever a result is held at the output.
//
// Ports:
//   ap_clk, ap_rst_n    clock, async active-low reset (synchronous release)
//   mode                0 = multiply, 1 = accumulate (latched at frame start)
//   in_valid/in_ready   input handshake; in_ready = !(out_valid && !out_ready)
//   in_a, in_b, in_last unsigned A, signed B, last beat of a MODE 1 frame
//   out_valid/out_ready output handshake
//   out_data            signed result, ACC_WIDTH bits
//   out_sat             saturation flag for the emitted result
//
// Build option: define SAMPLE_MAC_SAT_EN to saturate the product-to-term
// reduction and the accumulator add (and drive out_sat). Without it both
// operations wrap and out_sat is constant 0.
// -----------------------------------------------------------------------------
module sample_mac_pipe #(
  parameter int A_WIDTH   = 8,
  parameter int B_WIDTH   = 14,
  parameter int P_WIDTH   = 14,
  parameter int ACC_WIDTH = 32,
  parameter int NUM_STAGE = 3
) (
  input  logic                 ap_clk,
  input  logic                 ap_rst_n,
  input  logic                 mode,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [A_WIDTH-1:0]   in_a,
  input  logic [B_WIDTH-1:0]   in_b,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] out_data,
  output logic                 out_sat
);

  // Per-beat payload carried down the pipe. 'first' clears the accumulator
  // in the same cycle as the first add, so back-to-back frames need no gap.
  typedef struct packed {
    logic               mode;
    logic               first;
    logic               last;
    logic               sat;
    logic [P_WIDTH-1:0] t;
  } beat_t;

  logic                        advance, accept, eff_mode;
  logic                        in_frame_q, in_frame_d, mode_lat_q, mode_lat_d;
  logic signed [P_WIDTH-1:0]   term;
  logic                        term_sat;
  beat_t                       s1_d, src;
  logic [NUM_STAGE-1:0]        vld_pipe_q, vld_pipe_d;
  beat_t                       stg_q [NUM_STAGE];
  beat_t                       stg_d [NUM_STAGE];
  logic signed [ACC_WIDTH-1:0] t_ext, base, raw, sum;
  logic                        ovf;
  logic [ACC_WIDTH-1:0]        acc_q, acc_d, out_data_q, out_data_d;
  logic                        sat_acc_q, sat_acc_d;
  logic                        out_valid_q, out_valid_d, out_sat_q, out_sat_d;

  // Stall only when a result sits unaccepted at the output.
  assign advance  = !(out_valid_q && !out_ready);
  assign in_ready = advance;
  assign accept   = in_valid && advance;

  // Product is formed from the raw inputs and lands in stage 0; the
  // following stages give retiming room to spread the multiplier.
`ifdef SAMPLE_MAC_SAT_EN
  localparam int FW = A_WIDTH + B_WIDTH + 1;
  localparam logic signed [FW-1:0] T_MAX = {{(FW-P_WIDTH+1){1'b0}}, {(P_WIDTH-1){1'b1}}};
  localparam logic signed [FW-1:0] T_MIN = ~T_MAX;
  localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = ~ACC_MAX;
  logic signed [FW-1:0] prod;

  always_comb begin
    prod     = $signed({1'b0, in_a}) * $signed(in_b);
    term     = prod[P_WIDTH-1:0];
    term_sat = 1'b0;
    if (prod > T_MAX) begin
      term     = T_MAX[P_WIDTH-1:0];
      term_sat = 1'b1;
    end else if (prod < T_MIN) begin
      term     = T_MIN[P_WIDTH-1:0];
      term_sat = 1'b1;
    end
  end
`else
  // Low P_WIDTH bits of a signed product only depend on the operand LSBs,
  // so computing in the narrow context gives the exact wrapped term.
  always_comb begin
    term     = $signed({1'b0, in_a}) * $signed(in_b);
    term_sat = 1'b0;
  end
`endif

  // Frame tracking on the input side: mode is sampled on the first beat
  // and held for the rest of a MODE 1 frame. MODE 0 beats are single-beat
  // frames, so in_frame never sets for them.
  always_comb begin
    eff_mode   = in_frame_q ? mode_lat_q : mode;
    in_frame_d = in_frame_q;
    mode_lat_d = mode_lat_q;
    if (accept) begin
      in_frame_d = eff_mode && !in_last;
      mode_lat_d = eff_mode;
    end
    s1_d.mode  = eff_mode;
    s1_d.first = !in_frame_q;
    s1_d.last  = !eff_mode || in_last;
    s1_d.sat   = term_sat;
    s1_d.t     = term;
  end

  // Shift pipe; bubbles enter as cleared valid bits.
  always_comb begin
    vld_pipe_d = vld_pipe_q;
    stg_d      = stg_q;
    if (advance) begin
      vld_pipe_d[0] = accept;
      stg_d[0]      = s1_d;
      for (int i = 1; i < NUM_STAGE; i++) begin
        vld_pipe_d[i] = vld_pipe_q[i-1];
        stg_d[i]      = stg_q[i-1];
      end
    end
  end

  // Accumulate / output stage.
  always_comb begin
    src   = stg_q[NUM_STAGE-1];
    t_ext = ACC_WIDTH'($signed(src.t));
    base  = src.first ? '0 : $signed(acc_q);
    raw   = base + t_ext;
`ifdef SAMPLE_MAC_SAT_EN
    // Signed overflow: operands agree in sign, result does not.
    ovf = (base[ACC_WIDTH-1] == t_ext[ACC_WIDTH-1]) &&
          (raw[ACC_WIDTH-1] != base[ACC_WIDTH-1]);
    sum = ovf ? (base[ACC_WIDTH-1] ? ACC_MIN : ACC_MAX) : raw;
`else
    ovf = 1'b0;
    sum = raw;
`endif
    acc_d       = acc_q;
    sat_acc_d   = sat_acc_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sat_d   = out_sat_q;
    if (advance) begin
      out_valid_d = 1'b0;
      if (vld_pipe_q[NUM_STAGE-1]) begin
        if (src.mode) begin
          acc_d     = sum;
          sat_acc_d = (!src.first && sat_acc_q) || src.sat || ovf;
          if (src.last) begin
            out_valid_d = 1'b1;
            out_data_d  = sum;
            out_sat_d   = sat_acc_d;
          end
        end else begin
          out_valid_d = 1'b1;
          out_data_d  = t_ext;
          out_sat_d   = src.sat;
        end
      end
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      in_frame_q  <= 1'b0;
      mode_lat_q  <= 1'b0;
      vld_pipe_q  <= '0;
      for (int i = 0; i < NUM_STAGE; i++) stg_q[i] <= '0;
      acc_q       <= '0;
      sat_acc_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
    end else begin
      in_frame_q  <= in_frame_d;
      mode_lat_q  <= mode_lat_d;
      vld_pipe_q  <= vld_pipe_d;
      for (int i = 0; i < NUM_STAGE; i++) stg_q[i] <= stg_d[i];
      acc_q       <= acc_d;
      sat_acc_q   <= sat_acc_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sat_q   <= out_sat_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  // In the wrap build every sat source is constant 0, so this folds to 0.
  assign out_sat   = out_sat_q;

endmodule
